// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift up/down, parallel load.
// Optional end-around rotate; complementary outputs derived from Q.
module shift_reg_universal #(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter bit              ROTATE      = 1'b0
) (
  input  logic             CP,
  input  logic             CLR,
  input  logic             EN,
  input  logic [1:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             SO_UP,
  output logic             SO_DN
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] up;
  logic [WIDTH-1:0] dn;
  logic             in_up;
  logic             in_dn;

  // With rotate the end bit wraps; serial inputs are then unused.
  assign in_up = ROTATE ? q[WIDTH-1] : DSR;
  assign in_dn = ROTATE ? q[0] : DSL;

  generate
    if (WIDTH == 1) begin : g_w1
      assign up = in_up;
      assign dn = in_dn;
    end else begin : g_wn
      assign up = {q[WIDTH-2:0], in_up};
      assign dn = {in_dn, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      q <= RESET_VALUE;
    end else if (EN) begin
      case (S)
        2'b00:   q <= q;
        2'b01:   q <= up;
        2'b10:   q <= dn;
        2'b11:   q <= D;
        // Unknown mode poisons the state instead of picking a branch.
        default: q <= {WIDTH{1'bx}};
      endcase
    end
  end

  assign Q     = q;
  assign Qn    = ~q;
  assign SO_UP = q[WIDTH-1];
  assign SO_DN = q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed bench for shift_reg_universal.
// Four instances: plain, rotate, and single-bit plain/rotate.
module tb_shift_reg_universal;

  logic       CP = 1'b0;
  logic       CLR = 1'b0;
  logic       EN = 1'b0;
  logic [1:0] S = 2'b00;
  logic       DSR = 1'b0;
  logic       DSL = 1'b0;
  logic [3:0] D = 4'b0000;

  logic [3:0] q, qn, rq, rqn;
  logic       so_up, so_dn, rso_up, rso_dn;
  logic [0:0] wq, wqn, wrq, wrqn;
  logic       wso_up, wso_dn, wrso_up, wrso_dn;

  int checks = 0;
  int failures = 0;

  always #5 CP = ~CP;

  shift_reg_universal #(
    .WIDTH(4), .RESET_VALUE(4'b1010), .ROTATE(1'b0)
  ) u_dut (
    .CP(CP), .CLR(CLR), .EN(EN), .S(S), .DSR(DSR), .DSL(DSL),
    .D(D), .Q(q), .Qn(qn), .SO_UP(so_up), .SO_DN(so_dn)
  );

  shift_reg_universal #(
    .WIDTH(4), .RESET_VALUE(4'b0000), .ROTATE(1'b1)
  ) u_rot (
    .CP(CP), .CLR(CLR), .EN(EN), .S(S), .DSR(DSR), .DSL(DSL),
    .D(D), .Q(rq), .Qn(rqn), .SO_UP(rso_up), .SO_DN(rso_dn)
  );

  shift_reg_universal #(
    .WIDTH(1), .RESET_VALUE(1'b0), .ROTATE(1'b0)
  ) u_w1 (
    .CP(CP), .CLR(CLR), .EN(EN), .S(S), .DSR(DSR), .DSL(DSL),
    .D(D[0]), .Q(wq), .Qn(wqn), .SO_UP(wso_up), .SO_DN(wso_dn)
  );

  shift_reg_universal #(
    .WIDTH(1), .RESET_VALUE(1'b0), .ROTATE(1'b1)
  ) u_w1r (
    .CP(CP), .CLR(CLR), .EN(EN), .S(S), .DSR(DSR), .DSL(DSL),
    .D(D[0]), .Q(wrq), .Qn(wrqn), .SO_UP(wrso_up), .SO_DN(wrso_dn)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  initial begin
    // Asynchronous reset mid-cycle, before any clock edge
    #3 CLR = 1'b1;
    #1;
    chk("rst_q", q, 4'b1010);
    chk("rst_qn", qn, 4'b0101);
    chk("rst_so_up", so_up, 1'b1);
    chk("rst_so_dn", so_dn, 1'b0);
    chk("rst_rot_q", rq, 4'b0000);
    chk("rst_rot_qn", rqn, 4'b1111);
    EN = 1'b1; S = 2'b11; D = 4'b0110;
    tick();
    chk("rst_edge1", q, 4'b1010);
    tick();
    chk("rst_edge2", q, 4'b1010);
    #2 CLR = 1'b0;
    EN = 1'b0;
    tick();
    chk("rst_hold", q, 4'b1010);

    // Load / hold / enable
    EN = 1'b1; S = 2'b11; D = 4'b0110;
    tick();
    chk("load_q", q, 4'b0110);
    chk("load_qn", qn, 4'b1001);
    S = 2'b00; D = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", q, 4'b0110);
    end
    EN = 1'b0; S = 2'b11; D = 4'b1111;
    tick();
    chk("en_off", q, 4'b0110);

    // Shift up with DSR=1
    EN = 1'b1; S = 2'b11; D = 4'b0001;
    tick();
    chk("up_load", q, 4'b0001);
    S = 2'b01; DSR = 1'b1;
    tick();
    chk("up1", q, 4'b0011);
    tick();
    chk("up2", q, 4'b0111);
    tick();
    chk("up3", q, 4'b1111);
    chk("up3_so", so_up, 1'b1);
    chk("up3_qn", qn, 4'b0000);

    // Shift down with DSL=0
    S = 2'b11; D = 4'b1000;
    tick();
    S = 2'b10; DSL = 1'b0;
    tick();
    chk("dn1", q, 4'b0100);
    tick();
    chk("dn2", q, 4'b0010);
    tick();
    chk("dn3", q, 4'b0001);
    chk("dn3_so", so_dn, 1'b1);
    tick();
    chk("dn4", q, 4'b0000);
    chk("dn4_so", so_dn, 1'b0);

    // Rotate, with serial inputs toggled throughout
    S = 2'b11; D = 4'b1001;
    tick();
    chk("rot_load", rq, 4'b1001);
    chk("w1_load", wq, 1'b1);
    chk("w1r_load", wrq, 1'b1);
    S = 2'b01; DSR = 1'b0; DSL = 1'b1;
    tick();
    chk("rot_up", rq, 4'b0011);
    chk("plain_up", q, 4'b0010);
    chk("w1_up", wq, 1'b0);
    chk("w1r_up", wrq, 1'b1);
    S = 2'b10; DSR = 1'b1; DSL = 1'b1;
    tick();
    chk("rot_dn1", rq, 4'b1001);
    chk("plain_dn1", q, 4'b1001);
    chk("w1_dn1", wq, 1'b1);
    chk("w1r_dn1", wrq, 1'b1);
    DSR = 1'b0; DSL = 1'b0;
    tick();
    chk("rot_dn2", rq, 4'b1100);
    chk("rot_dn2_qn", rqn, 4'b0011);
    chk("w1_dn2", wq, 1'b0);
    chk("w1r_dn2", wrq, 1'b1);
    chk("w1_qn", wqn, 1'b1);

    // Async reset pulse during shift-up
    S = 2'b11; D = 4'b0111;
    tick();
    chk("ar_load", q, 4'b0111);
    S = 2'b01; DSR = 1'b1;
    #2 CLR = 1'b1;
    #1;
    chk("ar_now", q, 4'b1010);
    chk("ar_rot", rq, 4'b0000);
    #2 CLR = 1'b0;
    tick();
    chk("ar_resume1", q, 4'b0101);
    tick();
    chk("ar_resume2", q, 4'b1011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
